// File: rtl/rs_station_pkg.sv
// -----------------------------------------------------------------------------
// rs_station_pkg
// Shared definitions for the reservation station slice.
//  - Architectural widths for opcodes, register/ROB tags and instructions.
//  - MAXN: operand status value meaning "value present". Any other status value
//    holds a pending ROB tag in its low bits.
//  - Opcode encodings for the ops that are issued into the station.
//  - A small helper that tells whether an operand status means "value present".
// -----------------------------------------------------------------------------
package rs_station_pkg;

    localparam int OP_SIZE       = 6;
    localparam int REG_ADDR_SIZE = 5;
    localparam int INST_SIZE     = 32;

    localparam logic [31:0] MAXN = 32'hFFFF_FFFF;

    typedef enum logic [OP_SIZE-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_ADDI  = 6'd10,
        OP_ADD   = 6'd20,
        OP_SUB   = 6'd21,
        OP_XOR   = 6'd23,
        OP_OR    = 6'd24,
        OP_AND   = 6'd25
    } opcode_e;

    // Result of snooping one operand against both CDBs.
    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } cdb_pick_t;

    function automatic logic operand_present(input logic [31:0] status);
        return status == MAXN;
    endfunction

endpackage

// File: rtl/rs_station_select.sv
// -----------------------------------------------------------------------------
// rs_select
// Fixed-priority picker: the lowest set bit of mask wins.
// Ports:
//  mask    in   N        candidate bits
//  onehot  out  N        one-hot copy of the winning bit (all zero if none)
//  idx     out  IDX_W    binary index of the winning bit (0 if none)
//  any     out  1        at least one bit of mask is set
// -----------------------------------------------------------------------------
module rs_select #(
    parameter int N = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan upward; the first set bit found locks out all later ones.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !any) begin
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// -----------------------------------------------------------------------------
// rs_station
// Reservation station for ALU/branch/jump/lui/auipc ops. Holds up to DEPTH
// issued ops, snoops the ALU and LSB common data buses for pending operand
// tags, and dispatches one ready op per cycle to the ALU.
// Ports:
//  clk_in, rst_in           clock; synchronous active-low reset
//  rdy_in                   global enable, 0 stalls the station
//  clear                    mispredict flush, empties every entry
//  is_en, is_op             issue valid and opcode
//  is_q1/is_q2, is_v1/is_v2 operand status (MAXN = present, else tag) and value
//  is_rob                   destination ROB tag of the issued op
//  rs_full                  no free entry, issue must hold off
//  cdb_alu_*, cdb_lsb_*     broadcast valid / tag / value from both CDBs
//  alu_en, alu_op           dispatch pulse and opcode
//  alu_a, alu_b, alu_rob    dispatched operands and destination tag
// -----------------------------------------------------------------------------
module rs_station
    import rs_station_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OP_W  = OP_SIZE,
    parameter int TAG_W = REG_ADDR_SIZE
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             is_en,
    input  logic [OP_W-1:0]  is_op,
    input  logic [31:0]      is_q1,
    input  logic [31:0]      is_q2,
    input  logic [31:0]      is_v1,
    input  logic [31:0]      is_v2,
    input  logic [TAG_W-1:0] is_rob,
    output logic             rs_full,
    input  logic             cdb_alu_en,
    input  logic [TAG_W-1:0] cdb_alu_rob,
    input  logic [31:0]      cdb_alu_val,
    input  logic             cdb_lsb_en,
    input  logic [TAG_W-1:0] cdb_lsb_rob,
    input  logic [31:0]      cdb_lsb_val,
    output logic             alu_en,
    output logic [OP_W-1:0]  alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [TAG_W-1:0] alu_rob
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][OP_W-1:0]   op_q,    op_d;
    logic [DEPTH-1:0][31:0]       q1_q,    q1_d;
    logic [DEPTH-1:0][31:0]       q2_q,    q2_d;
    logic [DEPTH-1:0][31:0]       v1_q,    v1_d;
    logic [DEPTH-1:0][31:0]       v2_q,    v2_d;
    logic [DEPTH-1:0][TAG_W-1:0]  rob_q,   rob_d;

    logic             alu_en_q,  alu_en_d;
    logic [OP_W-1:0]  alu_op_q,  alu_op_d;
    logic [31:0]      alu_a_q,   alu_a_d;
    logic [31:0]      alu_b_q,   alu_b_d;
    logic [TAG_W-1:0] alu_rob_q, alu_rob_d;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] ready_onehot;
    logic [IDX_W-1:0] ready_idx;
    logic             ready_any;
    logic [DEPTH-1:0] free_onehot;
    logic [IDX_W-1:0] free_idx;
    logic             free_any;

    cdb_pick_t pick1, pick2;

    // A present operand (MAXN) is never compared, so a CDB tag equal to the
    // low bits of MAXN cannot disturb it. The ALU bus has priority.
    function automatic cdb_pick_t snoop(
        input logic [31:0]      status,
        input logic [31:0]      value,
        input logic             a_en,
        input logic [TAG_W-1:0] a_rob,
        input logic [31:0]      a_val,
        input logic             l_en,
        input logic [TAG_W-1:0] l_rob,
        input logic [31:0]      l_val
    );
        cdb_pick_t r;
        r.hit = 1'b0;
        r.val = value;
        if (!operand_present(status)) begin
            if (a_en && (a_rob == status[TAG_W-1:0])) begin
                r.hit = 1'b1;
                r.val = a_val;
            end else if (l_en && (l_rob == status[TAG_W-1:0])) begin
                r.hit = 1'b1;
                r.val = l_val;
            end
        end
        return r;
    endfunction

    // Readiness and fullness both look only at the registered entry state,
    // so an op woken this cycle waits one more edge and a slot freed this
    // cycle is not seen as free until the next.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && operand_present(q1_q[i]) && operand_present(q2_q[i]);
        end
    end

    assign rs_full = &valid_q;

    rs_select #(.N(DEPTH)) u_ready_pick (
        .mask   (ready_vec),
        .onehot (ready_onehot),
        .idx    (ready_idx),
        .any    (ready_any)
    );

    rs_select #(.N(DEPTH)) u_free_pick (
        .mask   (~valid_q),
        .onehot (free_onehot),
        .idx    (free_idx),
        .any    (free_any)
    );

    // Next-state: flush empties everything, stall holds everything, otherwise
    // wakeup, dispatch the lowest ready entry and write an issued op into the
    // lowest free entry. The free entry is never the dispatched one because
    // the dispatched entry is valid before the edge.
    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        rob_d     = rob_q;
        alu_en_d  = 1'b0;
        alu_op_d  = alu_op_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_rob_d = alu_rob_q;
        pick1     = '0;
        pick2     = '0;

        if (clear) begin
            valid_d = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                pick1 = snoop(q1_q[i], v1_q[i], cdb_alu_en, cdb_alu_rob, cdb_alu_val,
                              cdb_lsb_en, cdb_lsb_rob, cdb_lsb_val);
                pick2 = snoop(q2_q[i], v2_q[i], cdb_alu_en, cdb_alu_rob, cdb_alu_val,
                              cdb_lsb_en, cdb_lsb_rob, cdb_lsb_val);
                if (valid_q[i] && pick1.hit) begin
                    q1_d[i] = MAXN;
                    v1_d[i] = pick1.val;
                end
                if (valid_q[i] && pick2.hit) begin
                    q2_d[i] = MAXN;
                    v2_d[i] = pick2.val;
                end
            end

            if (ready_any) begin
                alu_en_d  = 1'b1;
                alu_op_d  = op_q[ready_idx];
                alu_a_d   = v1_q[ready_idx];
                alu_b_d   = v2_q[ready_idx];
                alu_rob_d = rob_q[ready_idx];
            end
            valid_d = valid_q & ~ready_onehot;

            if (is_en && !rs_full && free_any) begin
                pick1 = snoop(is_q1, is_v1, cdb_alu_en, cdb_alu_rob, cdb_alu_val,
                              cdb_lsb_en, cdb_lsb_rob, cdb_lsb_val);
                pick2 = snoop(is_q2, is_v2, cdb_alu_en, cdb_alu_rob, cdb_alu_val,
                              cdb_lsb_en, cdb_lsb_rob, cdb_lsb_val);
                valid_d         = valid_d | free_onehot;
                op_d[free_idx]  = is_op;
                rob_d[free_idx] = is_rob;
                q1_d[free_idx]  = pick1.hit ? MAXN : is_q1;
                v1_d[free_idx]  = pick1.val;
                q2_d[free_idx]  = pick2.hit ? MAXN : is_q2;
                v2_d[free_idx]  = pick2.val;
            end
        end
    end

    // Control state and dispatch outputs carry the reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q   <= '0;
            alu_en_q  <= 1'b0;
            alu_op_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_rob_q <= '0;
        end else begin
            valid_q   <= valid_d;
            alu_en_q  <= alu_en_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_rob_q <= alu_rob_d;
        end
    end

    // Entry payload is only meaningful under its valid bit, so it needs no reset.
    always_ff @(posedge clk_in) begin
        op_q  <= op_d;
        q1_q  <= q1_d;
        q2_q  <= q2_d;
        v1_q  <= v1_d;
        v2_q  <= v2_d;
        rob_q <= rob_d;
    end

    assign alu_en  = alu_en_q;
    assign alu_op  = alu_op_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_rob = alu_rob_q;

endmodule

// File: tb/tb_rs_station.sv
// -----------------------------------------------------------------------------
// tb_rs_station
// Directed bench for rs_station. Expected dispatches are queued when the op is
// driven and popped when alu_en is expected; every check is an immediate
// assertion that counts its own failures.
// -----------------------------------------------------------------------------
module tb_rs_station;
    import rs_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        is_en;
    logic [5:0]  is_op;
    logic [31:0] is_q1, is_q2, is_v1, is_v2;
    logic [4:0]  is_rob;
    logic        rs_full;
    logic        cdb_alu_en, cdb_lsb_en;
    logic [4:0]  cdb_alu_rob, cdb_lsb_rob;
    logic [31:0] cdb_alu_val, cdb_lsb_val;
    logic        alu_en;
    logic [5:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_rob;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rob;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    rs_station #(.DEPTH(8), .OP_W(6), .TAG_W(5)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear       (clear),
        .is_en       (is_en),
        .is_op       (is_op),
        .is_q1       (is_q1),
        .is_q2       (is_q2),
        .is_v1       (is_v1),
        .is_v2       (is_v2),
        .is_rob      (is_rob),
        .rs_full     (rs_full),
        .cdb_alu_en  (cdb_alu_en),
        .cdb_alu_rob (cdb_alu_rob),
        .cdb_alu_val (cdb_alu_val),
        .cdb_lsb_en  (cdb_lsb_en),
        .cdb_lsb_rob (cdb_lsb_rob),
        .cdb_lsb_val (cdb_lsb_val),
        .alu_en      (alu_en),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_rob     (alu_rob)
    );

    always #5 clk_in = ~clk_in;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [5:0] op,
                                 input logic [31:0] q1, input logic [31:0] v1,
                                 input logic [31:0] q2, input logic [31:0] v2,
                                 input logic [4:0] rob);
        is_en  = en;
        is_op  = op;
        is_q1  = q1;
        is_v1  = v1;
        is_q2  = q2;
        is_v2  = v2;
        is_rob = rob;
    endtask

    task automatic setCdb(input logic a_en, input logic [4:0] a_rob, input logic [31:0] a_val,
                          input logic l_en, input logic [4:0] l_rob, input logic [31:0] l_val);
        cdb_alu_en  = a_en;
        cdb_alu_rob = a_rob;
        cdb_alu_val = a_val;
        cdb_lsb_en  = l_en;
        cdb_lsb_rob = l_rob;
        cdb_lsb_val = l_val;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        setCdb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expectOp(input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rob);
        exp_t e;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.rob = rob;
        sb.push_back(e);
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input logic exp_en, input string tag);
        exp_t e;
        checkVal({tag, ".alu_en"}, {31'd0, alu_en}, {31'd0, exp_en});
        if (exp_en) begin
            checks++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("[TB] FAIL %s.scoreboard: observed empty queue expected an entry", tag);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkVal({tag, ".alu_op"},  {26'd0, alu_op},  {26'd0, e.op});
                checkVal({tag, ".alu_a"},   alu_a,            e.a);
                checkVal({tag, ".alu_b"},   alu_b,            e.b);
                checkVal({tag, ".alu_rob"}, {27'd0, alu_rob}, {27'd0, e.rob});
            end
        end
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        clear  = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        checkOutput(1'b0, "reset");
        checkVal("reset.alu_op",  {26'd0, alu_op},  32'd0);
        checkVal("reset.alu_a",   alu_a,            32'd0);
        checkVal("reset.alu_b",   alu_b,            32'd0);
        checkVal("reset.alu_rob", {27'd0, alu_rob}, 32'd0);
        checkVal("reset.rs_full", {31'd0, rs_full}, 32'd0);
        rst_in = 1'b1;
        tick();

        // 1: ready addi dispatches one cycle after issue; a CDB tag of 31
        // must not touch operands that are already present.
        $display("[TB] step 1: ready issue");
        applyStimulus(1'b1, OP_ADDI, MAXN, 32'd5, MAXN, 32'd7, 5'd3);
        setCdb(1'b1, 5'd31, 32'd99, 1'b1, 5'd31, 32'd98);
        expectOp(OP_ADDI, 32'd5, 32'd7, 5'd3);
        tick();
        idle();
        checkOutput(1'b0, "t1.issue_edge");
        tick();
        checkOutput(1'b1, "t1.dispatch");
        tick();
        checkOutput(1'b0, "t1.after");
        checkVal("t1.hold_a", alu_a, 32'd5);

        // 2: pending operand woken by the ALU CDB
        $display("[TB] step 2: cdb wakeup");
        applyStimulus(1'b1, OP_ADD, 32'd2, 32'd0, MAXN, 32'd1, 5'd6);
        tick();
        idle();
        checkOutput(1'b0, "t2.issue_edge");
        tick();
        checkOutput(1'b0, "t2.waiting");
        setCdb(1'b1, 5'd2, 32'd40, 1'b0, 5'd0, 32'd0);
        expectOp(OP_ADD, 32'd40, 32'd1, 5'd6);
        tick();
        idle();
        checkOutput(1'b0, "t2.wake_edge");
        tick();
        checkOutput(1'b1, "t2.dispatch");

        // 3: same-cycle bypass from the LSB CDB
        $display("[TB] step 3: issue bypass");
        applyStimulus(1'b1, OP_SUB, 32'd4, 32'd0, MAXN, 32'd2, 5'd7);
        setCdb(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd9);
        expectOp(OP_SUB, 32'd9, 32'd2, 5'd7);
        tick();
        idle();
        checkOutput(1'b0, "t3.issue_edge");
        tick();
        checkOutput(1'b1, "t3.dispatch");

        // 3b: both CDBs match the issuing operand; the ALU bus wins
        applyStimulus(1'b1, OP_AND, MAXN, 32'd3, 32'd8, 32'd0, 5'd9);
        setCdb(1'b1, 5'd8, 32'd11, 1'b1, 5'd8, 32'd22);
        expectOp(OP_AND, 32'd3, 32'd11, 5'd9);
        tick();
        idle();
        tick();
        checkOutput(1'b1, "t3b.alu_priority");

        // 3c: both operands woken in one cycle from different buses
        applyStimulus(1'b1, OP_OR, 32'd10, 32'd0, 32'd12, 32'd0, 5'd4);
        tick();
        idle();
        setCdb(1'b1, 5'd10, 32'd100, 1'b1, 5'd12, 32'd200);
        expectOp(OP_OR, 32'd100, 32'd200, 5'd4);
        tick();
        idle();
        checkOutput(1'b0, "t3c.wake_edge");
        tick();
        checkOutput(1'b1, "t3c.dispatch");

        // 4: fill all entries on tag 1, overflow issue dropped, index-order drain
        $display("[TB] step 4: full station");
        for (int i = 0; i < 8; i++) begin
            if (i == 7) checkVal("t4.not_full_at_7", {31'd0, rs_full}, 32'd0);
            applyStimulus(1'b1, OP_ADD, 32'd1, 32'd0, MAXN, 32'(i), 5'(i + 16));
            tick();
        end
        idle();
        checkVal("t4.full", {31'd0, rs_full}, 32'd1);
        applyStimulus(1'b1, OP_ADDI, MAXN, 32'd77, MAXN, 32'd88, 5'd30);
        setCdb(1'b1, 5'd1, 32'd100, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 8; i++) expectOp(OP_ADD, 32'd100, 32'(i), 5'(i + 16));
        tick();
        idle();
        checkVal("t4.full_after_wake", {31'd0, rs_full}, 32'd1);
        checkOutput(1'b0, "t4.wake_edge");
        tick();
        checkOutput(1'b1, "t4.drain0");
        checkVal("t4.full_drop", {31'd0, rs_full}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            checkOutput(1'b1, $sformatf("t4.drain%0d", i));
        end
        tick();
        checkOutput(1'b0, "t4.no_dropped_op");

        // 5: clear with same-cycle issue and matching CDB, then reset mid-run
        $display("[TB] step 5: clear and reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_XOR, 32'd3, 32'd0, MAXN, 32'd1, 5'(i));
            tick();
        end
        applyStimulus(1'b1, OP_ADDI, MAXN, 32'd1, MAXN, 32'd2, 5'd20);
        setCdb(1'b1, 5'd3, 32'd5, 1'b0, 5'd0, 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        checkOutput(1'b0, "t5.clear_edge");
        checkVal("t5.rs_full", {31'd0, rs_full}, 32'd0);
        setCdb(1'b1, 5'd3, 32'd5, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        checkOutput(1'b0, "t5.after_clear1");
        tick();
        checkOutput(1'b0, "t5.after_clear2");

        applyStimulus(1'b1, OP_OR, MAXN, 32'd1, MAXN, 32'd2, 5'd13);
        tick();
        idle();
        rst_in = 1'b0;
        tick();
        checkOutput(1'b0, "t5.reset");
        checkVal("t5.reset.alu_op",  {26'd0, alu_op},  32'd0);
        checkVal("t5.reset.alu_a",   alu_a,            32'd0);
        checkVal("t5.reset.alu_b",   alu_b,            32'd0);
        checkVal("t5.reset.alu_rob", {27'd0, alu_rob}, 32'd0);
        rst_in = 1'b1;
        tick();
        checkOutput(1'b0, "t5.after_reset");
        checkVal("t5.after_reset.rs_full", {31'd0, rs_full}, 32'd0);

        // 6: stall holds a ready entry until rdy_in returns
        $display("[TB] step 6: stall");
        applyStimulus(1'b1, OP_XOR, MAXN, 32'hAA, MAXN, 32'h55, 5'd12);
        expectOp(OP_XOR, 32'hAA, 32'h55, 5'd12);
        tick();
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput(1'b0, $sformatf("t6.stall%0d", i));
        end
        checkVal("t6.hold_a", alu_a, 32'd0);
        rdy_in = 1'b1;
        tick();
        checkOutput(1'b1, "t6.resume");
        tick();
        checkOutput(1'b0, "t6.after");

        checkVal("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
